// File: rtl/nn_pkg.sv
// Shared definitions for the MNIST inference datapath layers.
// Holds FSM state codes, accumulator sizing and lane index helpers.
package nn_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_BIAS   = 3'd2;
    localparam logic [2:0] ST_ARGMAX = 3'd3;
    localparam logic [2:0] ST_OUT    = 3'd4;

    // Enough headroom for n_in full-scale products without wrap.
    function automatic int acc_width(int dw, int ww, int n_in);
        return dw + ww + $clog2(n_in) + 1;
    endfunction

    // Upper bits of the finishing value that must all agree for
    // the value to fit the output width without clamping.
    function automatic int sat_hi_bits(int acc_w, int out_w);
        return acc_w + 1 - (out_w - 1);
    endfunction

    function automatic int lane_lo(int idx, int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One signed MAC lane: clear/enable accumulate, then bias, shift,
// ReLU and saturate into a registered output (y) with clamp flag (sat).
module nn_mac_lane
    import nn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WGT_W  = 32,
    parameter int BIAS_W = 64,
    parameter int OUT_W  = 40,
    parameter int ACC_W  = 75,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     fin,
    input  logic                     relu_en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [WGT_W-1:0]  w,
    input  logic signed [BIAS_W-1:0] b,
    output logic signed [OUT_W-1:0]  y,
    output logic                     sat
);

    localparam int SW = ACC_W + 1;
    localparam int HB = sat_hi_bits(ACC_W, OUT_W);

    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [DATA_W+WGT_W-1:0] prod;
    logic signed [SW-1:0]           sum, v;
    logic signed [OUT_W-1:0]        y_q, y_d, fin_y;
    logic                           fits;

    assign prod = x * w;

    always_comb begin
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = acc_q + ACC_W'(prod);
    end

    // One extra bit so a full-width bias cannot wrap the sum.
    always_comb begin
        sum = SW'(acc_q) + SW'(b);
        v   = sum >>> SHIFT;
        if (relu_en && v[SW-1])
            v = '0;
    end

    assign fits  = (&v[SW-1 -: HB]) | ~(|v[SW-1 -: HB]);
    assign fin_y = fits     ? v[OUT_W-1:0] :
                   v[SW-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                              {1'b0, {(OUT_W-1){1'b1}}};
    assign sat   = ~fits;
    assign y_d   = fin ? fin_y : y_q;
    assign y     = y_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q <= '0;
            y_q   <= '0;
        end else begin
            acc_q <= acc_d;
            y_q   <= y_d;
        end
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: streams activations into N_OUT MAC lanes,
// finishes each lane, scans for argmax and hands off via valid/ready.
module dense_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN   = 784,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 32,
    parameter int WGT_W  = 32,
    parameter int BIAS_W = 64,
    parameter int OUT_W  = 40,
    parameter int SHIFT  = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       relu_en,
    input  logic [$clog2(N_IN+1)-1:0]  n_in_cfg,
    input  logic [N_OUT*BIAS_W-1:0]    bias,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [DATA_W-1:0]          x_data,
    input  logic [N_OUT*WGT_W-1:0]     w_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_OUT*OUT_W-1:0]     y_data,
    output logic [$clog2(N_OUT)-1:0]   y_argmax,
    output logic                       sat_flag,
    output logic                       busy,
    output logic                       done
);

    localparam int ACC_W = acc_width(DATA_W, WGT_W, N_IN);
    localparam int CW    = $clog2(N_IN + 1);
    localparam int AW    = $clog2(N_OUT);

    logic [2:0]              state_q, state_d;
    logic                    relu_q, relu_d;
    logic [CW-1:0]           n_cfg_q, n_cfg_d, n_lim;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N_OUT*BIAS_W-1:0] bias_q, bias_d;
    logic [AW-1:0]           am_cnt_q, am_cnt_d;
    logic [AW-1:0]           arg_q, arg_d;
    logic signed [OUT_W-1:0] best_q, best_d, cur;
    logic                    sat_q, sat_d;
    logic                    done_q, done_d;
    logic                    clr, fin, beat;
    logic [N_OUT-1:0]        lane_sat;

    assign n_lim = (n_in_cfg > CW'(N_IN)) ? CW'(N_IN) : n_in_cfg;
    assign beat  = (state_q == ST_ACCUM) && x_valid;
    assign cur   = y_data[lane_lo(int'(am_cnt_q), OUT_W) +: OUT_W];

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        nn_mac_lane #(
            .DATA_W (DATA_W),
            .WGT_W  (WGT_W),
            .BIAS_W (BIAS_W),
            .OUT_W  (OUT_W),
            .ACC_W  (ACC_W),
            .SHIFT  (SHIFT)
        ) u_lane (
            .clk     (clk),
            .rstn    (rstn),
            .clr     (clr),
            .en      (beat),
            .fin     (fin),
            .relu_en (relu_q),
            .x       (x_data),
            .w       (w_data[lane_lo(j, WGT_W) +: WGT_W]),
            .b       (bias_q[lane_lo(j, BIAS_W) +: BIAS_W]),
            .y       (y_data[lane_lo(j, OUT_W) +: OUT_W]),
            .sat     (lane_sat[j])
        );
    end

    always_comb begin
        state_d  = state_q;
        relu_d   = relu_q;
        n_cfg_d  = n_cfg_q;
        cnt_d    = cnt_q;
        bias_d   = bias_q;
        am_cnt_d = am_cnt_q;
        arg_d    = arg_q;
        best_d   = best_q;
        sat_d    = sat_q;
        done_d   = 1'b0;
        clr      = 1'b0;
        fin      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    relu_d  = relu_en;
                    n_cfg_d = n_lim;
                    bias_d  = bias;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    clr     = 1'b1;
                    state_d = (n_lim == '0) ? ST_BIAS : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (x_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == n_cfg_q - CW'(1))
                        state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                fin      = 1'b1;
                sat_d    = |lane_sat;
                am_cnt_d = '0;
                state_d  = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                // Strict compare keeps the lowest index on ties.
                if (am_cnt_q == '0 || cur > best_q) begin
                    best_d = cur;
                    arg_d  = am_cnt_q;
                end
                am_cnt_d = am_cnt_q + AW'(1);
                if (am_cnt_q == AW'(N_OUT - 1))
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            relu_q   <= 1'b0;
            n_cfg_q  <= '0;
            cnt_q    <= '0;
            bias_q   <= '0;
            am_cnt_q <= '0;
            arg_q    <= '0;
            best_q   <= '0;
            sat_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            relu_q   <= relu_d;
            n_cfg_q  <= n_cfg_d;
            cnt_q    <= cnt_d;
            bias_q   <= bias_d;
            am_cnt_q <= am_cnt_d;
            arg_q    <= arg_d;
            best_q   <= best_d;
            sat_q    <= sat_d;
            done_q   <= done_d;
        end
    end

    assign x_ready   = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign y_argmax  = arg_q;
    assign sat_flag  = sat_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// Scoreboard bench for dense_layer_seq in a small 4-in/3-out setup.
// Expected results come from a behavioural model of the layer.
module tb_dense_layer_seq;

    localparam int N_IN   = 4;
    localparam int N_OUT  = 3;
    localparam int DATA_W = 8;
    localparam int WGT_W  = 8;
    localparam int BIAS_W = 16;
    localparam int OUT_W  = 12;
    localparam int SHIFT  = 0;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic                      start = 1'b0;
    logic                      relu_en = 1'b0;
    logic [2:0]                n_in_cfg = '0;
    logic [N_OUT*BIAS_W-1:0]   bias = '0;
    logic                      x_valid = 1'b0;
    logic                      x_ready;
    logic [DATA_W-1:0]         x_data = '0;
    logic [N_OUT*WGT_W-1:0]    w_data = '0;
    logic                      out_valid;
    logic                      out_ready = 1'b0;
    logic [N_OUT*OUT_W-1:0]    y_data;
    logic [1:0]                y_argmax;
    logic                      sat_flag;
    logic                      busy;
    logic                      done;

    always #5 clk = ~clk;

    dense_layer_seq #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DATA_W (DATA_W),
        .WGT_W  (WGT_W),
        .BIAS_W (BIAS_W),
        .OUT_W  (OUT_W),
        .SHIFT  (SHIFT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .relu_en   (relu_en),
        .n_in_cfg  (n_in_cfg),
        .bias      (bias),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x_data    (x_data),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_data    (y_data),
        .y_argmax  (y_argmax),
        .sat_flag  (sat_flag),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        longint y0;
        longint y1;
        longint y2;
        int     am;
        int     sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cx[4];
    int   cw[3];
    int   cb[3];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int relu, input int n);
        exp_t   e;
        longint v[3];
        longint hi;
        longint lo;
        int     s;
        int     am;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -(64'sd1 <<< (OUT_W - 1));
        s  = 0;
        for (int j = 0; j < 3; j++) begin
            longint acc;
            acc = 0;
            for (int i = 0; i < n; i++)
                acc += longint'(cx[i]) * longint'(cw[j]);
            v[j] = (acc + longint'(cb[j])) >>> SHIFT;
            if (relu != 0 && v[j] < 0)
                v[j] = 0;
            if (v[j] > hi) begin
                v[j] = hi;
                s = 1;
            end
            if (v[j] < lo) begin
                v[j] = lo;
                s = 1;
            end
        end
        am = 0;
        for (int j = 1; j < 3; j++)
            if (v[j] > v[am])
                am = j;
        e.y0  = v[0];
        e.y1  = v[1];
        e.y2  = v[2];
        e.am  = am;
        e.sat = s;
        sb.push_back(e);
    endtask

    task automatic drive_start(input int relu, input int n);
        start    = 1'b1;
        relu_en  = relu[0];
        n_in_cfg = 3'(n);
        for (int j = 0; j < 3; j++)
            bias[j*BIAS_W +: BIAS_W] = 16'(cb[j]);
        tick();
        start = 1'b0;
    endtask

    task automatic drive_beat(input int i);
        x_valid = 1'b1;
        x_data  = 8'(cx[i]);
        for (int j = 0; j < 3; j++)
            w_data[j*WGT_W +: WGT_W] = 8'(cw[j]);
        chk("beat_xready", x_ready, 1);
        tick();
        x_valid = 1'b0;
    endtask

    task automatic run(input int relu, input int n, input bit bp);
        exp_t              e;
        logic [35:0]       yexp;
        int                c;
        int                nn;
        nn = (n > N_IN) ? N_IN : n;
        push(relu, nn);
        chk("idle_xready", x_ready, 0);
        drive_start(relu, n);
        chk("busy_run", busy, 1);
        for (int i = 0; i < nn; i++) begin
            if (bp) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    start = 1'b1;
                    chk("gap_xready", x_ready, 1);
                    tick();
                end
                start = 1'b0;
            end
            drive_beat(i);
        end
        if (bp) begin
            x_valid = 1'b1;
            x_data  = 8'h55;
        end
        c = 1;
        while (!out_valid && c < 40) begin
            chk("wait_xready", x_ready, 0);
            if (bp)
                start = 1'b1;
            tick();
            c++;
        end
        chk("latency", c, N_OUT + 2);
        e    = sb.pop_front();
        yexp = {12'(e.y2), 12'(e.y1), 12'(e.y0)};
        if (bp) begin
            for (int k = 0; k < 10; k++) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_y", y_data, yexp);
                chk("hold_xready", x_ready, 0);
                start = 1'b1;
                tick();
            end
        end
        start   = 1'b0;
        x_valid = 1'b0;
        chk("y0", longint'($signed(y_data[11:0])), e.y0);
        chk("y1", longint'($signed(y_data[23:12])), e.y1);
        chk("y2", longint'($signed(y_data[35:24])), e.y2);
        chk("argmax", y_argmax, e.am);
        chk("sat", sat_flag, e.sat);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("done", done, 1);
        chk("ov_low", out_valid, 0);
        chk("busy_end", busy, 0);
        chk("y_kept", y_data, yexp);
        tick();
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #1;
        chk("rst_y", y_data, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_xr", x_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_am", y_argmax, 0);
        chk("rst_sat", sat_flag, 0);
        tick();
        rstn = 1'b1;
        tick();

        cx = '{1, 2, 3, 4};
        cw = '{1, 2, -1};
        cb = '{0, 10, 5};
        run(0, 4, 1'b0);
        run(1, 4, 1'b0);

        cx = '{127, 127, 127, 127};
        cw = '{127, -128, 0};
        cb = '{0, 0, 0};
        run(0, 4, 1'b0);

        cx = '{1, 2, 3, 4};
        cw = '{1, 2, -1};
        cb = '{0, 10, 5};
        run(0, 4, 1'b1);
        run(0, 7, 1'b0);

        cb = '{7, 7, 3};
        run(0, 0, 1'b0);

        cb = '{0, 10, 5};
        drive_start(0, 4);
        drive_beat(0);
        drive_beat(1);
        rstn = 1'b0;
        #1;
        chk("mid_y", y_data, 0);
        chk("mid_ov", out_valid, 0);
        chk("mid_xr", x_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_am", y_argmax, 0);
        chk("mid_sat", sat_flag, 0);
        tick();
        rstn = 1'b1;
        tick();
        run(0, 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
